seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a common-anode seven-segment display bank. It shares a single 7-bit segment bus between NUM_DIGITS digit positions, sequencing anode enables with a blanking guard between digits to prevent ghosting. Frame data is double-buffered so that updates never tear mid-frame. The `seg` output feeds the existing 7-bit segment splitter, which fans it out to the individual segment pins.

---
 rtl/seg_pkg.sv | 26 ++
 rtl/seg_frame_buf.sv | 46 ++++
 rtl/seg_scan_ctrl.sv | 130 +++++++++++++
 tb/tb_seg_scan_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Holds the segment width, FSM state encoding and the digit-slice helper.
package seg_pkg;

    localparam int unsigned SEG_W      = 7;
    localparam int unsigned MAX_DIGITS = 8;
    localparam int unsigned IDX_MAX_W  = 3;
    localparam int unsigned DATA_MAX_W = SEG_W * MAX_DIGITS;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } state_t;

    // Pattern of digit idx from a packed frame, zero-extended to the widest bank.
    function automatic logic [SEG_W-1:0] digit_slice(
        input logic [DATA_MAX_W-1:0] data,
        input logic [IDX_MAX_W-1:0]  idx
    );
        return data[32'(idx) * SEG_W +: SEG_W];
    endfunction

endpackage

// File: rtl/seg_frame_buf.sv
// Double frame buffer: load fills the shadow copy, swap commits it to the
// active copy at frame end so a frame is never shown half old, half new.
module seg_frame_buf
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load,
    input  logic [SEG_W*NUM_DIGITS-1:0]   digit_data,
    input  logic                          swap,
    input  logic [$clog2(NUM_DIGITS)-1:0] rd_idx,
    output logic [SEG_W-1:0]              rd_seg_c,
    output logic                          pending
);

    localparam int unsigned DATA_W = SEG_W * NUM_DIGITS;

    logic [DATA_W-1:0] shadow;
    logic [DATA_W-1:0] active;

    // A load coinciding with a swap commits the old shadow and keeps pending set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= '0;
            active  <= '0;
            pending <= 1'b0;
        end else begin
            if (swap && pending) begin
                active <= shadow;
            end
            if (load) begin
                shadow  <= digit_data;
                pending <= 1'b1;
            end else if (swap) begin
                pending <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_seg_c = digit_slice(DATA_MAX_W'(active), IDX_MAX_W'(rd_idx));
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan controller: walks the digits with a dark guard between
// them and drives registered segment/anode outputs from the next state.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        enable,
    input  logic [SEG_W*NUM_DIGITS-1:0] digit_data,
    input  logic                        load,
    output logic [SEG_W-1:0]            seg,
    output logic [NUM_DIGITS-1:0]       an_n,
    output logic                        frame_done,
    output logic                        pending
);

    localparam int unsigned IDX_W   = $clog2(NUM_DIGITS);
    localparam int unsigned CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    state_t             state;
    state_t             state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nx;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_nx;
    logic               swap;
    logic [SEG_W-1:0]   rd_seg_c;
    logic [SEG_W-1:0]   seg_nx;
    logic [NUM_DIGITS-1:0] an_n_nx;

    seg_frame_buf #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_frame_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .digit_data (digit_data),
        .swap       (swap),
        .rd_idx     (idx_nx),
        .rd_seg_c   (rd_seg_c),
        .pending    (pending)
    );

    // State, counter, index and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            seg        <= SEG_BLANK;
            an_n       <= '1;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            idx        <= idx_nx;
            seg        <= seg_nx;
            an_n       <= an_n_nx;
            frame_done <= swap;
        end
    end

    // Next-state logic; swap marks the SHOW exit of the last digit.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        idx_nx   = idx;
        swap     = 1'b0;
        if (!enable) begin
            state_nx = IDLE;
            cnt_nx   = '0;
            idx_nx   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nx = BLANK;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                end
                BLANK: begin
                    if (cnt == BLANK_LAST) begin
                        state_nx = SHOW;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (cnt == SHOW_LAST) begin
                        state_nx = BLANK;
                        cnt_nx   = '0;
                        if (idx == IDX_LAST) begin
                            idx_nx = '0;
                            swap   = 1'b1;
                        end else begin
                            idx_nx = idx + IDX_W'(1);
                        end
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                    idx_nx   = '0;
                end
            endcase
        end
    end

    // Output decode from the next state so outputs move with the state.
    always_comb begin
        seg_nx  = SEG_BLANK;
        an_n_nx = '1;
        if (state_nx == SHOW) begin
            seg_nx  = rd_seg_c;
            an_n_nx = ~(NUM_DIGITS'(1) << idx_nx);
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with 4 digits, 4-cycle lit time, 2-cycle guard.
// Edge numbering: edge 0 is the first edge sampling enable high after reset.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic        load;
    logic [27:0] digit_data;
    logic [6:0]  seg;
    logic [3:0]  an_n;
    logic        frame_done;
    logic        pending;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int ecount    = -1;

    logic [27:0] p1 = {7'h4F, 7'h5B, 7'h06, 7'h3F};
    logic [27:0] p2 = {7'h07, 7'h7D, 7'h6D, 7'h66};

    seg_scan_ctrl #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (4),
        .BLANK_CYCLES (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .digit_data (digit_data),
        .load       (load),
        .seg        (seg),
        .an_n       (an_n),
        .frame_done (frame_done),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] pat_digit(input logic [27:0] p, input int d);
        return p[d*7 +: 7];
    endfunction

    function automatic logic [3:0] an_for(input int d);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << d);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        ecount++;
    endtask

    task automatic go_to(input int n);
        while (ecount < n) tick();
    endtask

    task automatic do_reset();
        @(negedge clk);
        enable = 1'b0;
        load   = 1'b0;
        rst_n  = 1'b0;
        #2;
        rst_n  = 1'b1;
        ecount = -1;
    endtask

    task automatic start_with(input logic [27:0] p);
        digit_data = p;
        load       = 1'b1;
        enable     = 1'b1;
        tick();
        load       = 1'b0;
    endtask

    task automatic load_at(input int e, input logic [27:0] p);
        go_to(e - 1);
        digit_data = p;
        load       = 1'b1;
        tick();
        load       = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; load = 1'b0; digit_data = '0;
        #12;
        total_cnt++; if (an_n !== 4'hF) $display("FAIL reset_an_n got %h want f", an_n); else pass_cnt++;
        total_cnt++; if (seg !== 7'h00) $display("FAIL reset_seg got %h want 00", seg); else pass_cnt++;
        total_cnt++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done got %b want 0", frame_done); else pass_cnt++;
        total_cnt++; if (pending !== 1'b0) $display("FAIL reset_pending got %b want 0", pending); else pass_cnt++;
        @(negedge clk);
        rst_n  = 1'b1;
        ecount = -1;
        start_with(p1);
        go_to(3);
        total_cnt++; if (an_n !== 4'b1110) $display("FAIL pre_reset_an_n got %b want 1110", an_n); else pass_cnt++;
        total_cnt++; if (pending !== 1'b1) $display("FAIL pre_reset_pending got %b want 1", pending); else pass_cnt++;
        #2;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (an_n !== 4'hF) $display("FAIL async_reset_an_n got %b want 1111", an_n); else pass_cnt++;
        total_cnt++; if (seg !== 7'h00) $display("FAIL async_reset_seg got %h want 00", seg); else pass_cnt++;
        total_cnt++; if (pending !== 1'b0) $display("FAIL async_reset_pending got %b want 0", pending); else pass_cnt++;
        enable = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_frame();
        int r, d, q;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        logic       exp_fd;
        logic       exp_pend;
        do_reset();
        start_with(p1);
        for (int e = 0; e < 50; e++) begin
            go_to(e);
            r = e % 24; d = r / 6; q = r % 6;
            exp_an   = (q >= 2) ? an_for(d) : 4'hF;
            exp_seg  = (q >= 2 && e >= 24) ? pat_digit(p1, d) : 7'h00;
            exp_fd   = (r == 0 && e > 0);
            exp_pend = (e < 24);
            total_cnt++; if (an_n !== exp_an) $display("FAIL frame_an_n edge %0d got %b want %b", e, an_n, exp_an); else pass_cnt++;
            total_cnt++; if (seg !== exp_seg) $display("FAIL frame_seg edge %0d got %h want %h", e, seg, exp_seg); else pass_cnt++;
            total_cnt++; if (frame_done !== exp_fd) $display("FAIL frame_done edge %0d got %b want %b", e, frame_done, exp_fd); else pass_cnt++;
            total_cnt++; if (pending !== exp_pend) $display("FAIL frame_pending edge %0d got %b want %b", e, pending, exp_pend); else pass_cnt++;
        end
    endtask

    task automatic test_load_midframe();
        do_reset();
        start_with(p1);
        load_at(30, p2);
        total_cnt++; if (pending !== 1'b1) $display("FAIL mid_pending_set got %b want 1", pending); else pass_cnt++;
        go_to(38);
        total_cnt++; if (seg !== 7'h5B || an_n !== 4'b1011) $display("FAIL mid_old_digit2 got %h/%b want 5b/1011", seg, an_n); else pass_cnt++;
        go_to(47);
        total_cnt++; if (seg !== 7'h4F || pending !== 1'b1) $display("FAIL mid_old_digit3 got %h/%b want 4f/1", seg, pending); else pass_cnt++;
        go_to(48);
        total_cnt++; if (frame_done !== 1'b1 || pending !== 1'b0) $display("FAIL mid_swap got fd=%b pend=%b want 1/0", frame_done, pending); else pass_cnt++;
        go_to(50);
        total_cnt++; if (seg !== 7'h66 || an_n !== 4'b1110) $display("FAIL mid_new_digit0 got %h/%b want 66/1110", seg, an_n); else pass_cnt++;
        go_to(56);
        total_cnt++; if (seg !== 7'h6D || an_n !== 4'b1101) $display("FAIL mid_new_digit1 got %h/%b want 6d/1101", seg, an_n); else pass_cnt++;
    endtask

    task automatic test_load_on_frame_end();
        do_reset();
        start_with(p1);
        load_at(24, p2);
        total_cnt++; if (frame_done !== 1'b1) $display("FAIL fe_frame_done got %b want 1", frame_done); else pass_cnt++;
        total_cnt++; if (pending !== 1'b1) $display("FAIL fe_pending_kept got %b want 1", pending); else pass_cnt++;
        go_to(26);
        total_cnt++; if (seg !== 7'h3F) $display("FAIL fe_old_shadow_digit0 got %h want 3f", seg); else pass_cnt++;
        go_to(47);
        total_cnt++; if (pending !== 1'b1) $display("FAIL fe_pending_hold got %b want 1", pending); else pass_cnt++;
        go_to(48);
        total_cnt++; if (frame_done !== 1'b1 || pending !== 1'b0) $display("FAIL fe_second_swap got fd=%b pend=%b want 1/0", frame_done, pending); else pass_cnt++;
        go_to(50);
        total_cnt++; if (seg !== 7'h66) $display("FAIL fe_new_digit0 got %h want 66", seg); else pass_cnt++;
    endtask

    task automatic test_enable_drop();
        do_reset();
        start_with(p1);
        load_at(30, p2);
        go_to(39);
        total_cnt++; if (an_n !== 4'b1011 || seg !== 7'h5B) $display("FAIL drop_pre got %b/%h want 1011/5b", an_n, seg); else pass_cnt++;
        enable = 1'b0;
        tick();
        total_cnt++; if (an_n !== 4'hF || seg !== 7'h00) $display("FAIL drop_dark got %b/%h want 1111/00", an_n, seg); else pass_cnt++;
        total_cnt++; if (frame_done !== 1'b0) $display("FAIL drop_no_frame_done got %b want 0", frame_done); else pass_cnt++;
        total_cnt++; if (pending !== 1'b1) $display("FAIL drop_pending_kept got %b want 1", pending); else pass_cnt++;
        tick();
        total_cnt++; if (an_n !== 4'hF || frame_done !== 1'b0) $display("FAIL drop_idle got %b/%b want 1111/0", an_n, frame_done); else pass_cnt++;
        enable = 1'b1;
        tick();
        total_cnt++; if (an_n !== 4'hF || frame_done !== 1'b0) $display("FAIL reen_blank0 got %b/%b want 1111/0", an_n, frame_done); else pass_cnt++;
        tick();
        total_cnt++; if (an_n !== 4'hF) $display("FAIL reen_blank1 got %b want 1111", an_n); else pass_cnt++;
        tick();
        total_cnt++; if (an_n !== 4'b1110 || seg !== 7'h3F) $display("FAIL reen_digit0 got %b/%h want 1110/3f", an_n, seg); else pass_cnt++;
        total_cnt++; if (pending !== 1'b1) $display("FAIL reen_pending got %b want 1", pending); else pass_cnt++;
    endtask

    task automatic test_invariants();
        logic [3:0] lo;
        do_reset();
        start_with(p2);
        for (int e = 1; e < 60; e++) begin
            if (e == 10 || e == 37) begin
                enable = 1'b0;
            end else begin
                enable = 1'b1;
            end
            tick();
            lo = ~an_n;
            total_cnt++; if ((lo & (lo - 4'd1)) !== 4'd0) $display("FAIL inv_one_anode edge %0d got %b want at most one low", e, an_n); else pass_cnt++;
            total_cnt++; if (an_n === 4'hF && seg !== 7'h00) $display("FAIL inv_dark_seg edge %0d got %h want 00", e, seg); else pass_cnt++;
        end
    endtask

    initial begin
        enable = 1'b0;
        load = 1'b0;
        digit_data = '0;
        test_reset();
        test_frame();
        test_load_midframe();
        test_load_on_frame_end();
        test_enable_drop();
        test_invariants();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
